// File: rtl/msg_scroll_ctrl.sv
// Scan/sequencing controller for the 4-digit circular message display:
// debounced advance button, auto-scroll, and frame-aligned pointer commits.
module msg_scroll_ctrl #(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SCAN_CYCLES     = 16,
  parameter int BLANK_CYCLES    = 2,
  parameter int AUTO_FRAMES     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic       auto_en,
  output logic       an3,
  output logic       an2,
  output logic       an1,
  output logic       an0,
  output logic [1:0] digit_sel,
  output logic [3:0] char_idx,
  output logic [3:0] msg_ptr,
  output logic       frame_start
);

  localparam int DWW = $clog2(((SCAN_CYCLES > BLANK_CYCLES) ? SCAN_CYCLES : BLANK_CYCLES) + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int FCW = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;

  // Encoding runs BLANK3,DIG3,BLANK2,...,DIG0 so bit0 marks a lit digit and
  // bits[2:1] equal 3-n, which is also the char_idx offset from msg_ptr.
  localparam logic [2:0] BLANK3 = 3'd0;
  localparam logic [2:0] DIG0   = 3'd7;

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic [DWW-1:0] dwell;
  logic           dwell_last;
  logic           commit;

  logic           btn_p0;
  logic           btn_p1;
  logic           stable;
  logic [DBW-1:0] db_cnt;
  logic           db_flip;
  logic           rise;

  logic           pending;
  logic [FCW-1:0] frame_cnt;
  logic           advance;
  logic [3:0]     ptr_nxt;

  always_comb begin
    dwell_last = state[0] ? (dwell == DWW'(SCAN_CYCLES - 1))
                          : (dwell == DWW'(BLANK_CYCLES - 1));
    commit     = dwell_last && (state == DIG0);
    state_nxt  = dwell_last ? state + 3'd1 : state;
    db_flip    = (btn_p1 != stable) && (db_cnt == DBW'(DEBOUNCE_CYCLES - 1));
    rise       = db_flip && btn_p1;
    advance    = pending || (auto_en && (frame_cnt == FCW'(AUTO_FRAMES - 1)));
    ptr_nxt    = (commit && advance) ? msg_ptr + 4'd1 : msg_ptr;
  end

  // Button synchronizer and debounce
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      stable <= 1'b0;
      db_cnt <= '0;
    end else begin
      btn_p0 <= button;
      btn_p1 <= btn_p0;
      if (btn_p1 != stable) begin
        if (db_flip) begin
          stable <= btn_p1;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Advance bookkeeping; a rise on the commit cycle survives into the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (rise)
        pending <= 1'b1;
      else if (commit)
        pending <= 1'b0;

      if (!auto_en)
        frame_cnt <= '0;
      else if (commit)
        frame_cnt <= advance ? '0 : frame_cnt + 1'b1;
    end
  end

  // Scan schedule; outputs are registered from the next-state view
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= BLANK3;
      dwell                <= '0;
      msg_ptr              <= 4'd0;
      digit_sel            <= 2'd3;
      char_idx             <= 4'd0;
      {an3, an2, an1, an0} <= 4'b1111;
      frame_start          <= 1'b0;
    end else begin
      state       <= state_nxt;
      dwell       <= dwell_last ? '0 : dwell + 1'b1;
      msg_ptr     <= ptr_nxt;
      digit_sel   <= ~state_nxt[2:1];
      char_idx    <= ptr_nxt + {2'b00, state_nxt[2:1]};
      {an3, an2, an1, an0} <= state_nxt[0] ? ~(4'b0001 << (~state_nxt[2:1])) : 4'b1111;
      frame_start <= commit;
    end
  end

endmodule

// File: tb/tb_msg_scroll_ctrl.sv
// Self-checking bench for msg_scroll_ctrl: directed scenarios with randomized
// timing, every output compared each cycle against a frame-position model.
`timescale 1ns/1ps
module tb_msg_scroll_ctrl;

  localparam int FRAME = 72;
  localparam int SEG   = 18;
  localparam int BLANK = 2;
  localparam int DEB   = 8;
  localparam int AF    = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic       auto_en = 1'b0;
  logic       an3, an2, an1, an0;
  logic [1:0] digit_sel;
  logic [3:0] char_idx;
  logic [3:0] msg_ptr;
  logic       frame_start;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model state: position in the 72-cycle frame plus spec-level bookkeeping.
  int m_pos = 0;
  int m_ptr = 0;
  bit m_fs = 1'b0;
  bit m_s0 = 1'b0;
  bit m_s1 = 1'b0;
  bit m_stable = 1'b0;
  int m_run = 0;
  bit m_pending = 1'b0;
  int m_fcnt = 0;

  msg_scroll_ctrl dut (
    .clk(clk), .reset(reset), .button(button), .auto_en(auto_en),
    .an3(an3), .an2(an2), .an1(an1), .an0(an0),
    .digit_sel(digit_sel), .char_idx(char_idx), .msg_ptr(msg_ptr),
    .frame_start(frame_start)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_pos = 0; m_ptr = 0; m_fs = 1'b0; m_s0 = 1'b0; m_s1 = 1'b0;
    m_stable = 1'b0; m_run = 0; m_pending = 1'b0; m_fcnt = 0;
  endtask

  task automatic model_step();
    bit rise;
    bit commit;
    rise = 1'b0;
    if (m_s1 != m_stable) begin
      m_run++;
      if (m_run == DEB) begin
        m_stable = m_s1;
        m_run = 0;
        rise = m_stable;
      end
    end else begin
      m_run = 0;
    end
    m_s1 = m_s0;
    m_s0 = button;
    commit = (m_pos == FRAME - 1);
    if (commit) begin
      if (m_pending || (auto_en && m_fcnt == AF - 1)) begin
        m_ptr = (m_ptr + 1) % 16;
        m_fcnt = 0;
      end else if (auto_en) begin
        m_fcnt++;
      end
      m_pending = 1'b0;
    end
    if (rise) m_pending = 1'b1;
    if (!auto_en) m_fcnt = 0;
    m_fs = commit;
    m_pos = (m_pos + 1) % FRAME;
  endtask

  task automatic check_outputs();
    int seg;
    int w;
    int n;
    logic [3:0] e_an;
    seg = m_pos / SEG;
    w = m_pos % SEG;
    n = 3 - seg;
    e_an = (w < BLANK) ? 4'hF : ~(4'b0001 << n);
    check("anodes", 32'({an3, an2, an1, an0}), 32'(e_an));
    check("digit_sel", 32'(digit_sel), n);
    check("char_idx", 32'(char_idx), (m_ptr + 3 - n) % 16);
    check("msg_ptr", 32'(msg_ptr), m_ptr);
    check("frame_start", 32'(frame_start), 32'(m_fs));
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) check_outputs();
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fs();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_fs && k < 4 * FRAME);
    if (!m_fs) begin
      tests++;
      fails++;
      $error("FAIL wait_fs: observed no frame start after %0d cycles, expected within %0d", k, FRAME);
    end
  endtask

  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (m_pos != p && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    if (m_pos != p) begin
      tests++;
      fails++;
      $error("FAIL wait_pos: observed position %0d expected %0d", m_pos, p);
    end
  endtask

  task automatic press(input int hold);
    button = 1'b1;
    tick(hold);
    button = 1'b0;
    tick(12);
  endtask

  // Edge changes that would coincide with a rising clock edge are nudged by 1 ns.
  task automatic bounce_edge(input logic v);
    if (($time % 20) == 10) #1;
    button = v;
  endtask

  initial begin
    chk_en = 1'b1;
    tick(3);
    check("rst_anodes", 32'({an3, an2, an1, an0}), 32'hF);
    check("rst_digit_sel", 32'(digit_sel), 3);
    check("rst_char_idx", 32'(char_idx), 0);
    check("rst_msg_ptr", 32'(msg_ptr), 0);
    check("rst_frame_start", 32'(frame_start), 0);
    reset = 1'b1;

    // Free-running scan
    tick(2 * FRAME + 5);
    wait_fs();
    check("freerun_ptr", 32'(msg_ptr), 0);

    // Bouncy press then long hold
    repeat ($urandom_range(3, 6)) begin
      #($urandom_range(5, 15));
      bounce_edge(~button);
    end
    #($urandom_range(5, 15));
    bounce_edge(1'b1);
    @(negedge clk);
    tick(50);
    button = 1'b0;
    wait_fs();
    check("bounce_ptr", 32'(msg_ptr), 1);
    check("bounce_char_idx", 32'(char_idx), 1);
    wait_fs();
    check("bounce_single", 32'(msg_ptr), 1);

    // Remaining 15 presses wrap the pointer to 0
    for (int i = 0; i < 15; i++) begin
      tick($urandom_range(0, 15));
      press($urandom_range(12, 30));
      wait_fs();
    end
    check("wrap_ptr", 32'(msg_ptr), 0);

    // Two presses in one frame give one advance
    press(12);
    press(12);
    wait_fs();
    check("two_press_ptr", 32'(msg_ptr), 1);
    wait_fs();
    check("two_press_hold", 32'(msg_ptr), 1);

    // Stable rising edge lands exactly on the commit edge
    wait_pos(FRAME - 1 - (DEB + 1));
    button = 1'b1;
    wait_fs();
    check("edge_on_commit_now", 32'(msg_ptr), 1);
    tick(15);
    button = 1'b0;
    wait_fs();
    check("edge_on_commit_next", 32'(msg_ptr), 2);

    // Auto-scroll from reset, with a button press merging into an auto tick
    reset = 1'b0;
    auto_en = 1'b1;
    tick(2);
    reset = 1'b1;
    for (int f = 1; f <= 24; f++) begin
      if (f == 16) begin
        tick($urandom_range(0, 20));
        press(12);
      end
      wait_fs();
      if (f == 7)  check("auto_f7", 32'(msg_ptr), 0);
      if (f == 8)  check("auto_f8", 32'(msg_ptr), 1);
      if (f == 15) check("auto_f15", 32'(msg_ptr), 1);
      if (f == 16) check("auto_merge_f16", 32'(msg_ptr), 2);
      if (f == 23) check("auto_f23", 32'(msg_ptr), 2);
      if (f == 24) check("auto_f24", 32'(msg_ptr), 3);
    end
    auto_en = 1'b0;
    repeat (10) wait_fs();
    check("auto_off", 32'(msg_ptr), 3);

    // Asynchronous reset in the middle of DIG2 with a press pending
    button = 1'b1;
    wait_pos(SEG + BLANK + 5);
    #5;
    reset = 1'b0;
    #1;
    check("midrst_anodes", 32'({an3, an2, an1, an0}), 32'hF);
    check("midrst_msg_ptr", 32'(msg_ptr), 0);
    check("midrst_digit_sel", 32'(digit_sel), 3);
    check("midrst_char_idx", 32'(char_idx), 0);
    button = 1'b0;
    @(negedge clk);
    tick(2);
    reset = 1'b1;
    repeat (2) wait_fs();
    check("midrst_press_lost", 32'(msg_ptr), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
